// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared widths, rounding-mode type and the normalizer stage payload
package fpnew_pkg;
   localparam int unsigned ExpWidth    = 8;
   localparam int unsigned ManWidth    = 23;
   localparam int unsigned MantInWidth = 48;
   localparam int unsigned LzcWidth    = $clog2(MantInWidth + 1);
   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100,
      ROD = 3'b101,
      DYN = 3'b111
   } roundmode_e;
   typedef struct packed {
      logic                       sign;
      logic signed [ExpWidth+1:0] exp;
      logic [MantInWidth-1:0]     mant;
      logic                       sticky;
      roundmode_e                 rnd_mode;
      logic [LzcWidth-1:0]        lzc;
      logic                       zero;
   } norm_stage_t;
endpackage

// File: rtl/fpnew_norm_sticky_if.sv
// fpnew_norm_sticky_if: operand-in / rounding-ready-out bus of the normalizer
interface fpnew_norm_sticky_if;
   import fpnew_pkg::*;
   logic                            flush_i;
   logic                            in_valid_i;
   logic                            in_ready_o;
   logic                            sign_i;
   logic signed [ExpWidth+1:0]      exp_i;
   logic [MantInWidth-1:0]          mant_i;
   logic                            sticky_i;
   roundmode_e                      rnd_mode_i;
   logic                            out_valid_o;
   logic                            out_ready_i;
   logic [ExpWidth+ManWidth-1:0]    abs_value_o;
   logic [1:0]                      round_sticky_bits_o;
   logic                            sign_o;
   roundmode_e                      rnd_mode_o;
   logic                            of_o;
   logic                            busy_o;
   modport slave (
      input  flush_i, in_valid_i, sign_i, exp_i, mant_i, sticky_i, rnd_mode_i, out_ready_i,
      output in_ready_o, out_valid_o, abs_value_o, round_sticky_bits_o, sign_o, rnd_mode_o, of_o, busy_o
   );
   modport master (
      output flush_i, in_valid_i, sign_i, exp_i, mant_i, sticky_i, rnd_mode_i, out_ready_i,
      input  in_ready_o, out_valid_o, abs_value_o, round_sticky_bits_o, sign_o, rnd_mode_o, of_o, busy_o
   );
endinterface

// File: rtl/fpnew_lzc.sv
// fpnew_lzc: leading-zero counter with all-zero flag (count = Width when empty)
module fpnew_lzc #(
   parameter int unsigned Width    = 48,
   parameter int unsigned CntWidth = $clog2(Width + 1)
) (
   input  logic [Width-1:0]    data,
   output logic [CntWidth-1:0] cnt,
   output logic                empty
);
   // the highest set bit is visited last and therefore wins
   always_comb begin
      cnt = CntWidth'(Width);
      for (int i = 0; i < Width; i++) if (data[i]) cnt = CntWidth'(Width - 1 - i);
   end
   assign empty = ~|data;
endmodule

// File: rtl/fpnew_norm_sticky.sv
// fpnew_norm_sticky: two-stage normalizer producing {exp, mant}, round/sticky and overflow
module fpnew_norm_sticky
   import fpnew_pkg::*;
(
   input logic                clk_i,
   input logic                rst_ni,
   fpnew_norm_sticky_if.slave bus
);
   localparam int unsigned MW = MantInWidth;
   localparam int unsigned EW = ExpWidth + 4;
   localparam logic signed [EW-1:0] MW_S    = EW'(MW);
   localparam logic signed [EW-1:0] MAX_EXP = EW'((1 << ExpWidth) - 1);
   logic s1_valid, s2_valid, s2_ready, in_ready;
   logic [LzcWidth-1:0] lzc;
   logic lzc_zero;
   norm_stage_t s1_d, s1_q;
   logic signed [EW-1:0] exp_s, lzc_s, e_s, sh_s, rsh;
   logic [2*MW-2:0] wide;
   logic sub, ovf, rnd, stk;
   logic [ManWidth-1:0] man;
   logic [ExpWidth+ManWidth-1:0] abs_d, abs_q;
   logic [1:0] rs_d, rs_q;
   logic sign_q, of_q;
   roundmode_e rnd_q;
   fpnew_lzc #(.Width(MW), .CntWidth(LzcWidth)) i_lzc (
      .data  (bus.mant_i),
      .cnt   (lzc),
      .empty (lzc_zero)
   );
   assign s1_d = '{sign: bus.sign_i, exp: bus.exp_i, mant: bus.mant_i, sticky: bus.sticky_i,
                   rnd_mode: bus.rnd_mode_i, lzc: lzc, zero: lzc_zero};
   assign s2_ready = ~s2_valid | bus.out_ready_i;
   assign in_ready = ~s1_valid | s2_ready;
   // input stage: capture the operand and its leading-zero count on handshake
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else begin
         if (bus.flush_i) s1_valid <= 1'b0;
         else if (in_ready) s1_valid <= bus.in_valid_i;
         if (bus.in_valid_i && in_ready) s1_q <= s1_d;
      end
   end
   // normalize: left by lzc when the result stays normal, otherwise align to exponent 1
   always_comb begin
      exp_s = EW'($signed(s1_q.exp));
      lzc_s = EW'({1'b0, s1_q.lzc});
      e_s   = exp_s - lzc_s;
      sub   = e_s < EW'(1);
      ovf   = ~s1_q.zero & (e_s >= MAX_EXP);
      sh_s  = sub ? exp_s - EW'(1) : lzc_s;
      rsh   = (sh_s < -MW_S) ? MW_S : -sh_s;
      wide  = (2*MW-1)'(sh_s[EW-1] ? {s1_q.mant, {MW{1'b0}}} >> rsh : {s1_q.mant, {MW{1'b0}}} << sh_s);
      man   = wide[2*MW-2 -: ManWidth];
      rnd   = wide[2*MW-2-ManWidth];
      stk   = |wide[2*MW-3-ManWidth:0] | s1_q.sticky;
      abs_d = s1_q.zero ? '0 : ovf ? {{ExpWidth{1'b1}}, {ManWidth{1'b0}}}
                                   : {sub ? ExpWidth'(0) : e_s[ExpWidth-1:0], man};
      rs_d  = s1_q.zero ? {1'b0, s1_q.sticky} : ovf ? 2'b00 : {rnd, stk};
   end
   // output stage: hold the result until the rounding stage takes it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_valid <= 1'b0;
         abs_q    <= '0;
         rs_q     <= '0;
         sign_q   <= 1'b0;
         of_q     <= 1'b0;
         rnd_q    <= RNE;
      end else begin
         if (bus.flush_i) s2_valid <= 1'b0;
         else if (s2_ready) s2_valid <= s1_valid;
         if (s1_valid && s2_ready) begin
            abs_q  <= abs_d;
            rs_q   <= rs_d;
            sign_q <= s1_q.sign;
            of_q   <= ovf;
            rnd_q  <= s1_q.rnd_mode;
         end
      end
   end
   assign bus.in_ready_o          = in_ready;
   assign bus.out_valid_o         = s2_valid;
   assign bus.abs_value_o         = abs_q;
   assign bus.round_sticky_bits_o = rs_q;
   assign bus.sign_o              = sign_q;
   assign bus.rnd_mode_o          = rnd_q;
   assign bus.of_o                = of_q;
   assign bus.busy_o              = s1_valid | s2_valid;
endmodule

// File: tb/tb_fpnew_norm_sticky.sv
// tb_fpnew_norm_sticky: directed vectors, pipeline corner sequences and a randomized scoreboard run
module tb_fpnew_norm_sticky;
   import fpnew_pkg::*;
   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;
   fpnew_norm_sticky_if bus ();
   fpnew_norm_sticky dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));
   typedef struct packed {
      logic [2:0]  rnd;
      logic        sign;
      logic        of;
      logic [1:0]  rs;
      logic [30:0] abs;
   } res_t;
   typedef struct {
      int          e;
      logic [47:0] m;
      logic        st;
      logic [30:0] abs;
      logic [1:0]  rs;
      logic        of;
   } vec_t;
   typedef struct {
      logic        s;
      int          e;
      logic [47:0] m;
      logic        st;
      logic [2:0]  r;
   } op_t;
   int n_chk = 0;
   int n_fail = 0;
   res_t sb[$];
   vec_t vecs[$];
   op_t ops[3];
   // value = mant * 2^(exp-47); pick the ulp grid (normal: 23 bits below the leading one,
   // subnormal: fixed at biased exponent 1) and split the value on that grid
   function automatic res_t model(input logic s, input int exp, input logic [47:0] mant,
                                  input logic st, input logic [2:0] r);
      res_t res;
      int p, e, k;
      logic [127:0] big, q;
      res = '0;
      res.rnd = r;
      res.sign = s;
      if (mant == 0) begin
         res.rs = {1'b0, st};
         return res;
      end
      p = 0;
      for (int i = 0; i < 48; i++) if (mant[i]) p = i;
      e = exp - (47 - p);
      if (e >= 255) begin
         res.abs = {8'hFF, 23'h0};
         res.of = 1'b1;
         return res;
      end
      k = (e >= 1 ? p - 23 : 25 - exp) + 64;
      if (k >= 128) begin
         res.rs = 2'b01;
         return res;
      end
      big = {16'h0, mant, 64'h0};
      q = big >> k;
      res.abs = {e >= 1 ? e[7:0] : 8'h00, q[22:0]};
      res.rs = {big[k-1], ((big & ((128'(1) << (k - 1)) - 128'(1))) != 0) | st};
      return res;
   endfunction
   function automatic res_t model_op(input op_t o);
      return model(o.s, o.e, o.m, o.st, o.r);
   endfunction
   function automatic res_t obs();
      return {bus.rnd_mode_o, bus.sign_o, bus.of_o, bus.round_sticky_bits_o, bus.abs_value_o};
   endfunction
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, req, $time);
      end
   endtask
   task automatic drive(input logic s, input int e, input logic [47:0] m, input logic st, input logic [2:0] r);
      bus.sign_i = s;
      bus.exp_i = e[9:0];
      bus.mant_i = m;
      bus.sticky_i = st;
      bus.rnd_mode_i = roundmode_e'(r);
   endtask
   task automatic apply(input op_t o);
      drive(o.s, o.e, o.m, o.st, o.r);
   endtask
   initial begin
      res_t exp_r;
      logic rdy[4];
      int acc;
      int e;
      logic [47:0] m;
      logic [63:0] t;
      logic s, st;
      logic [2:0] r;
      bus.flush_i = 1'b0;
      bus.in_valid_i = 1'b0;
      bus.out_ready_i = 1'b1;
      drive(1'b0, 0, '0, 1'b0, 3'd0);
      vecs.push_back('{127, 48'h8000_0000_0000, 1'b0, 31'h3F80_0000, 2'b00, 1'b0});
      vecs.push_back('{150, 48'h0000_0100_0000, 1'b0, 31'h3F80_0000, 2'b00, 1'b0});
      vecs.push_back('{127, 48'h8000_0080_0000, 1'b0, 31'h3F80_0000, 2'b10, 1'b0});
      vecs.push_back('{127, 48'h8000_0080_0001, 1'b0, 31'h3F80_0000, 2'b11, 1'b0});
      vecs.push_back('{127, 48'h8000_0080_0000, 1'b1, 31'h3F80_0000, 2'b11, 1'b0});
      vecs.push_back('{0,   48'h8000_0000_0000, 1'b0, 31'h0040_0000, 2'b00, 1'b0});
      vecs.push_back('{0,   48'h8000_0100_0000, 1'b0, 31'h0040_0000, 2'b10, 1'b0});
      vecs.push_back('{-60, 48'h8000_0000_0000, 1'b0, 31'h0000_0000, 2'b01, 1'b0});
      vecs.push_back('{300, 48'h8000_0000_0000, 1'b0, 31'h7F80_0000, 2'b00, 1'b1});
      vecs.push_back('{127, 48'h0000_0000_0000, 1'b1, 31'h0000_0000, 2'b01, 1'b0});
      vecs.push_back('{1,   48'h8000_0000_0000, 1'b0, 31'h0080_0000, 2'b00, 1'b0});
      vecs.push_back('{254, 48'h8000_0000_0000, 1'b0, 31'h7F00_0000, 2'b00, 1'b0});
      vecs.push_back('{255, 48'h8000_0000_0000, 1'b0, 31'h7F80_0000, 2'b00, 1'b1});
      vecs.push_back('{127, 48'h0000_0000_0001, 1'b0, 31'h2800_0000, 2'b00, 1'b0});
      ops[0] = '{1'b0, 130, 48'h0000_4000_0001, 1'b0, 3'd1};
      ops[1] = '{1'b1, 20,  48'h0123_4567_89AB, 1'b1, 3'd2};
      ops[2] = '{1'b0, 260, 48'h0000_0000_F00D, 1'b0, 3'd4};
      repeat (3) @(negedge clk_i);
      chk("rst_out_valid", bus.out_valid_o, 0);
      chk("rst_busy", bus.busy_o, 0);
      chk("rst_outputs", obs(), 0);
      rst_ni = 1'b1;
      #1 chk("rst_in_ready", bus.in_ready_o, 1);
      foreach (vecs[i]) begin
         @(negedge clk_i);
         drive(1'(i % 2), vecs[i].e, vecs[i].m, vecs[i].st, 3'(i % 5));
         bus.in_valid_i = 1'b1;
         @(negedge clk_i);
         bus.in_valid_i = 1'b0;
         chk($sformatf("vec%0d_early", i), bus.out_valid_o, 0);
         @(negedge clk_i);
         exp_r = '{rnd: 3'(i % 5), sign: 1'(i % 2), of: vecs[i].of, rs: vecs[i].rs, abs: vecs[i].abs};
         chk($sformatf("vec%0d_valid", i), bus.out_valid_o, 1);
         chk($sformatf("vec%0d_result", i), obs(), exp_r);
      end
      @(negedge clk_i);
      bus.out_ready_i = 1'b0;
      acc = 0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk_i);
         apply(ops[acc]);
         bus.in_valid_i = 1'b1;
         #1;
         rdy[c] = bus.in_ready_o;
         if (c >= 2) begin
            chk("bp_hold_valid", bus.out_valid_o, 1);
            chk("bp_hold_data", obs(), model_op(ops[0]));
         end
         if (rdy[c]) acc++;
         @(posedge clk_i);
      end
      chk("bp_accepted", acc, 2);
      chk("bp_ready_c2", rdy[2], 0);
      chk("bp_ready_c3", rdy[3], 0);
      @(negedge clk_i);
      apply(ops[2]);
      bus.out_ready_i = 1'b1;
      #1 chk("bp_rel_ready", bus.in_ready_o, 1);
      chk("bp_out0", obs(), model_op(ops[0]));
      @(negedge clk_i);
      bus.in_valid_i = 1'b0;
      chk("bp_out1_valid", bus.out_valid_o, 1);
      chk("bp_out1", obs(), model_op(ops[1]));
      @(negedge clk_i);
      chk("bp_out2_valid", bus.out_valid_o, 1);
      chk("bp_out2", obs(), model_op(ops[2]));
      @(negedge clk_i);
      chk("bp_empty", bus.out_valid_o, 0);
      bus.out_ready_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_i);
         apply(ops[c]);
         bus.in_valid_i = 1'b1;
      end
      @(negedge clk_i);
      apply(ops[2]);
      bus.out_ready_i = 1'b1;
      bus.flush_i = 1'b1;
      #1 chk("fl_full_valid", bus.out_valid_o, 1);
      chk("fl_full_busy", bus.busy_o, 1);
      chk("fl_ready", bus.in_ready_o, 1);
      @(negedge clk_i);
      bus.flush_i = 1'b0;
      bus.in_valid_i = 1'b0;
      chk("fl_out_valid", bus.out_valid_o, 0);
      chk("fl_busy", bus.busy_o, 0);
      @(negedge clk_i);
      chk("fl_discarded", bus.busy_o, 0);
      for (int c = 0; c < 400; c++) begin
         @(negedge clk_i);
         t = {$urandom(), $urandom()};
         m = t[47:0] >> $urandom_range(0, 48);
         if ($urandom_range(0, 9) == 0) m = '0;
         e = int'($urandom_range(0, 420)) - 110;
         s = 1'($urandom_range(0, 1));
         st = 1'($urandom_range(0, 1));
         r = 3'($urandom_range(0, 4));
         drive(s, e, m, st, r);
         bus.in_valid_i = $urandom_range(0, 3) != 0;
         bus.out_ready_i = $urandom_range(0, 3) != 0;
         #1;
         if (bus.out_valid_o && bus.out_ready_i) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rnd_extra: got unexpected output %h, expected none", obs());
            end else chk("rnd_result", obs(), sb.pop_front());
         end
         if (bus.in_valid_i && bus.in_ready_o) sb.push_back(model(s, e, m, st, r));
      end
      @(negedge clk_i);
      bus.in_valid_i = 1'b0;
      bus.out_ready_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (bus.out_valid_o) begin
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL rnd_drain_extra: got unexpected output %h, expected none", obs());
            end else chk("rnd_drain", obs(), sb.pop_front());
         end
         @(negedge clk_i);
      end
      chk("rnd_drained", sb.size(), 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         apply(ops[c]);
         bus.in_valid_i = 1'b1;
      end
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      #1 chk("arst_out_valid", bus.out_valid_o, 0);
      chk("arst_busy", bus.busy_o, 0);
      chk("arst_outputs", obs(), 0);
      @(negedge clk_i);
      bus.in_valid_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      apply(ops[1]);
      bus.in_valid_i = 1'b1;
      #1 chk("arst_in_ready", bus.in_ready_o, 1);
      @(negedge clk_i);
      bus.in_valid_i = 1'b0;
      chk("arst_lat_early", bus.out_valid_o, 0);
      @(negedge clk_i);
      chk("arst_lat_valid", bus.out_valid_o, 1);
      chk("arst_lat_result", obs(), model_op(ops[1]));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
